gate_bist_ctrl: RTL
===================

# gate_bist_ctrl

Built-in self-test sequencer for a single 2-input logic gate cell such as `nand_gate`. On a start pulse it drives the gate's `A`/`B` inputs through all four combinations for a programmable number of passes. After a settle window it samples `Y` and compares it against a 4-bit expected truth table, then reports pass/fail, a per-vector failure mask and an error count. It sits between a test host (or top-level control) and the gate under test, replacing the open-loop stimulus used at gate level with a synthesizable, self-checking controller.

## Interface
Parameters:
- `SETTLE_CYC`, default 2: cycles each vector is held before `Y` is sampled; legal range 1..255.
- `N_PASSES`, default 1: full 4-vector sweeps per run; legal range 1..65535.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high; it is the only reset.
- `start`  in  1  run request; sampled only in IDLE.
- `exp_tt`  in  4  expected truth table; bit i is the expected `Y` for {A,B}=i (NAND = 4'b0111); latched on accepted start.
- `stop_on_fail`  in  1  abort the run on the first mismatch; latched on accepted start.
- `A`  out  1  gate input A (MSB of the vector index).
- `B`  out  1  gate input B (LSB of the vector index).
- `Y`  in  1  gate output under test.
- `busy`  out  1  high from the cycle after an accepted start through the last DRIVE cycle.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  run result, held until the next accepted start.
- `fail_mask`  out  4  sticky per-vector mismatch flags, bit i for vector i.
- `err_cnt`  out  8  mismatch count, saturating at 255.

## Operation
- Three states: IDLE, DRIVE, DONE.
- **IDLE**
  - `A`=`B`=0, `busy`=0.
  - `start`=1 → latch `exp_tt` and `stop_on_fail`; clear `fail_mask`, `err_cnt` and `pass`; set vec_idx=0, pass_cnt=0, settle_cnt=0; go to DRIVE.
- **DRIVE**
  - {A,B}=vec_idx (registered outputs).
  - settle_cnt increments each cycle.
  - In the cycle where settle_cnt==SETTLE_CYC-1, `Y` is sampled at the closing edge and compared with exp_tt[vec_idx].
  - On a mismatch: set fail_mask[vec_idx]; increment err_cnt unless it is 255.
  - After the sample, settle_cnt returns to 0 and vec_idx increments, wrapping 3→0.
  - On that wrap, pass_cnt increments.
  - Leave for DONE when pass_cnt reaches N_PASSES at the wrap, or immediately on a mismatch when stop_on_fail=1.
- **DONE** (one cycle)
  - `done`=1.
  - `pass`=1 if err_cnt==0 including the final sample, else 0.
  - `A`=`B`=0, `busy`=0.
  - Always proceeds to IDLE.
- `start` during DRIVE or DONE is ignored and not queued.
- `exp_tt` and `stop_on_fail` changes during a run have no effect.
- `fail_mask`, `err_cnt` and `pass` hold their values after DONE until the next accepted start.
- Width rules:
  - settle_cnt is 8 bits.
  - pass_cnt is 16 bits.
  - err_cnt saturates and never wraps.
- Simultaneous events: the final sample's mismatch is counted and included in `pass` in the same DONE cycle.

## Timing
- Reset values: `A`=0, `B`=0, `busy`=0, `done`=0, `pass`=0, `fail_mask`=0, `err_cnt`=0; state IDLE, all counters 0.
- `rst`=1 mid-run returns to IDLE at the next edge, clears all outputs to reset values and emits no `done`.
- With `start` sampled at edge E0:
  - Vector 0 appears on `A`/`B` after E0.
  - Each vector is held exactly SETTLE_CYC cycles.
  - `Y` for vector k of pass p is sampled at edge E0 + (4p+k+1)·SETTLE_CYC.
- Full run (no abort): `done` is high in the cycle after edge E0 + 4·N_PASSES·SETTLE_CYC, and the next `start` is accepted one cycle later.
- Abort on mismatch: DONE immediately follows the failing sample edge; `A`/`B` return to 0 in the DONE cycle.
- `Y` is assumed stable for the final settle cycle (a combinational gate meets this at SETTLE_CYC ≥ 1).

## Test plan
- **Correct NAND.** Setup: real NAND, `exp_tt`=4'b0111, SETTLE_CYC=2, N_PASSES=1. Required:
  - {A,B} sequence 00,01,10,11, two cycles each.
  - `done` pulse 9 cycles after the start edge.
  - `pass`=1, `fail_mask`=0000, `err_cnt`=0.
- **Stuck-at-1 output.** Setup: `Y` tied 1, `exp_tt`=4'b0111, N_PASSES=3, `stop_on_fail`=0. Required: `fail_mask`=1000, `err_cnt`=3, `pass`=0, full-length run.
- **Abort on first failure.** Setup: `Y` tied 0, `stop_on_fail`=1. Required:
  - Mismatch on vector 0.
  - `done` 1 cycle after the first sample edge.
  - `fail_mask`=0001, `err_cnt`=1, `A`=`B`=0 at `done`.
- **Saturation.** Setup: `Y` = ~NAND, N_PASSES=100, SETTLE_CYC=1. Required: `err_cnt`=255 (not 400 mod 256), `fail_mask`=1111, `pass`=0.
- **Start while busy.** Setup: pulse `start` mid-run and in the DONE cycle. Required: no restart, `done` timing unchanged; a `start` one cycle after DONE begins a new run with results cleared.
- **Reset mid-run.** Setup: assert `rst` during vector 2. Required: next cycle all outputs at reset values, no `done` pulse; a subsequent start runs normally.

Source files
------------

// File: rtl/gate_bist_ctrl.sv
// Self-test sequencer for one 2-input gate: sweeps {A,B} through 00..11 for
// N_PASSES passes, samples Y after a settle window and scores it against exp_tt.
module gate_bist_ctrl #(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned N_PASSES   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] exp_tt,
    input  logic       stop_on_fail,
    output logic       A,
    output logic       B,
    input  logic       Y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_mask,
    output logic [7:0] err_cnt,
    output logic [1:0] dbg_state_o
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRIVE = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [7:0]  SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [15:0] PASS_LAST   = 16'(N_PASSES - 1);

    logic [1:0]  state_q,      state_d;
    logic [1:0]  vec_idx_q,    vec_idx_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic [15:0] pass_cnt_q,   pass_cnt_d;
    logic [3:0]  exp_tt_q,     exp_tt_d;
    logic        stop_q,       stop_d;
    logic [3:0]  fail_mask_q,  fail_mask_d;
    logic [7:0]  err_cnt_q,    err_cnt_d;
    logic        pass_q,       pass_d;
    logic [1:0]  ab_q,         ab_d;

    logic sample_now;
    logic mismatch;
    logic wrap;
    logic last_pass;

    // Y is scored at the edge that closes the last settle cycle of a vector.
    assign sample_now = (state_q == ST_DRIVE) && (settle_cnt_q == SETTLE_LAST);
    assign mismatch   = sample_now && (Y != exp_tt_q[vec_idx_q]);
    assign wrap       = sample_now && (vec_idx_q == 2'd3);
    assign last_pass  = wrap && (pass_cnt_q == PASS_LAST);

    always_comb begin
        state_d      = state_q;
        vec_idx_d    = vec_idx_q;
        settle_cnt_d = settle_cnt_q;
        pass_cnt_d   = pass_cnt_q;
        exp_tt_d     = exp_tt_q;
        stop_d       = stop_q;
        fail_mask_d  = fail_mask_q;
        err_cnt_d    = err_cnt_q;
        pass_d       = pass_q;
        ab_d         = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_tt_d     = exp_tt;
                    stop_d       = stop_on_fail;
                    fail_mask_d  = 4'b0000;
                    err_cnt_d    = 8'd0;
                    pass_d       = 1'b0;
                    vec_idx_d    = 2'd0;
                    pass_cnt_d   = 16'd0;
                    settle_cnt_d = 8'd0;
                    state_d      = ST_DRIVE;
                end
            end

            ST_DRIVE: begin
                settle_cnt_d = settle_cnt_q + 8'd1;
                if (mismatch) begin
                    fail_mask_d[vec_idx_q] = 1'b1;
                    if (err_cnt_q != 8'hFF) begin
                        err_cnt_d = err_cnt_q + 8'd1;
                    end
                end
                if (sample_now) begin
                    settle_cnt_d = 8'd0;
                    vec_idx_d    = vec_idx_q + 2'd1;
                    if (wrap) begin
                        pass_cnt_d = pass_cnt_q + 16'd1;
                    end
                end
                // The final sample's verdict is folded into pass on the same edge.
                if (last_pass || (mismatch && stop_q)) begin
                    state_d = ST_DONE;
                    pass_d  = (err_cnt_d == 8'd0);
                    ab_d    = 2'b00;
                end else begin
                    ab_d = vec_idx_d;
                end
            end

            ST_DONE: begin
                state_d      = ST_IDLE;
                vec_idx_d    = 2'd0;
                settle_cnt_d = 8'd0;
                pass_cnt_d   = 16'd0;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            vec_idx_q    <= 2'd0;
            settle_cnt_q <= 8'd0;
            pass_cnt_q   <= 16'd0;
            exp_tt_q     <= 4'b0000;
            stop_q       <= 1'b0;
            fail_mask_q  <= 4'b0000;
            err_cnt_q    <= 8'd0;
            pass_q       <= 1'b0;
            ab_q         <= 2'b00;
        end else begin
            state_q      <= state_d;
            vec_idx_q    <= vec_idx_d;
            settle_cnt_q <= settle_cnt_d;
            pass_cnt_q   <= pass_cnt_d;
            exp_tt_q     <= exp_tt_d;
            stop_q       <= stop_d;
            fail_mask_q  <= fail_mask_d;
            err_cnt_q    <= err_cnt_d;
            pass_q       <= pass_d;
            ab_q         <= ab_d;
        end
    end

    assign A           = ab_q[1];
    assign B           = ab_q[0];
    assign busy        = (state_q == ST_DRIVE);
    assign done        = (state_q == ST_DONE);
    assign pass        = pass_q;
    assign fail_mask   = fail_mask_q;
    assign err_cnt     = err_cnt_q;
    assign dbg_state_o = state_q;

endmodule
